// File: rtl/activation_pkg.sv
// Shared constants and types for the activation stage and its stream packer.
package activation_pkg;

    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned MATRIX_SIZE = 196;

    localparam logic [1:0] FUNC_RELU    = 2'b00;
    localparam logic [1:0] FUNC_SIGMOID = 2'b01;
    localparam logic [1:0] FUNC_TANH    = 2'b10;
    localparam logic [1:0] FUNC_SOFTMAX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2
    } packer_state_t;

endpackage

// File: rtl/activation_stream_packer_if.sv
// Configuration and element-stream handshakes feeding the packer.
interface activation_stream_packer_if #(
    parameter int unsigned DATA_WIDTH = activation_pkg::DATA_WIDTH
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [31:0]                  cfg_size;
    logic [1:0]                   cfg_func;
    logic                         s_valid;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_last;

    modport master (
        output cfg_valid, cfg_size, cfg_func, s_valid, s_data, s_last,
        input  cfg_ready, s_ready
    );

    modport slave (
        input  cfg_valid, cfg_size, cfg_func, s_valid, s_data, s_last,
        output cfg_ready, s_ready
    );
endinterface

// File: rtl/activation_stream_packer_fsm.sv
// Packer control: IDLE/FILL/ISSUE sequencing, element count, handshakes, sticky errors.
module packer_fsm
    import activation_pkg::*;
#(
    parameter int unsigned SLOTS     = 196,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [31:0]          cfg_size,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 cfg_ready,
    output logic                 s_ready,
    output logic                 cfg_take,
    output logic                 wr_en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 err_len,
    output logic                 err_cfg
);

    packer_state_t        state;
    packer_state_t        state_next;
    logic [CNT_WIDTH-1:0] size_q;
    logic                 cfg_ok;
    logic                 cfg_hs;
    logic                 s_hs;
    logic                 at_end;

    assign cfg_ok = (cfg_size != 32'd0) && (cfg_size <= 32'(SLOTS));
    assign cfg_hs = cfg_valid && cfg_ready;
    assign s_hs   = s_valid && s_ready;
    // size_q fits CNT_WIDTH because only in-range sizes are ever latched
    assign at_end = (count == size_q - CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cfg_hs && cfg_ok) state_next = ST_FILL;
            ST_FILL:  if (s_hs && (at_end || s_last)) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        valid_out = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE:  cfg_ready = !rst;
            ST_FILL:  begin s_ready = !rst; busy = 1'b1; end
            ST_ISSUE: begin valid_out = 1'b1; busy = 1'b1; end
            default:  busy = 1'b0;
        endcase
    end

    assign cfg_take = cfg_hs && cfg_ok;
    assign wr_en    = s_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            size_q  <= '0;
            err_len <= 1'b0;
            err_cfg <= 1'b0;
        end else begin
            if (cfg_take) begin
                count  <= '0;
                size_q <= CNT_WIDTH'(cfg_size);
            end else if (s_hs) begin
                count <= count + CNT_WIDTH'(1);
            end
            if (cfg_hs && !cfg_ok)              err_cfg <= 1'b1;
            if (s_hs && (s_last != at_end))     err_len <= 1'b1;
        end
    end

endmodule

// File: rtl/activation_stream_packer.sv
// Collects a byte-serial element stream into a zero-filled matrix and issues it as one pulse.
module activation_stream_packer #(
    parameter int unsigned DATA_WIDTH  = activation_pkg::DATA_WIDTH,
    parameter int unsigned MATRIX_SIZE = activation_pkg::MATRIX_SIZE,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    activation_stream_packer_if.slave    bus,
    output logic signed [DATA_WIDTH-1:0] matrix_out [MATRIX_SIZE],
    output logic [31:0]                  matrix_size_out,
    output logic [1:0]                   func_sel_out,
    output logic                         valid_out,
    output logic                         busy,
    output logic                         err_len,
    output logic                         err_cfg
);

    logic                 cfg_ready;
    logic                 s_ready;
    logic                 cfg_take;
    logic                 wr_en;
    logic [CNT_WIDTH-1:0] count;

    assign bus.cfg_ready = cfg_ready;
    assign bus.s_ready   = s_ready;

    packer_fsm #(
        .SLOTS     (MATRIX_SIZE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (bus.cfg_valid),
        .cfg_size  (bus.cfg_size),
        .s_valid   (bus.s_valid),
        .s_last    (bus.s_last),
        .cfg_ready (cfg_ready),
        .s_ready   (s_ready),
        .cfg_take  (cfg_take),
        .wr_en     (wr_en),
        .count     (count),
        .valid_out (valid_out),
        .busy      (busy),
        .err_len   (err_len),
        .err_cfg   (err_cfg)
    );

    // Buffer holds the issued matrix until the next accepted config clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MATRIX_SIZE; i++) matrix_out[i] <= '0;
            matrix_size_out <= '0;
            func_sel_out    <= '0;
        end else if (cfg_take) begin
            for (int unsigned i = 0; i < MATRIX_SIZE; i++) matrix_out[i] <= '0;
            matrix_size_out <= bus.cfg_size;
            func_sel_out    <= bus.cfg_func;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
                if (count == CNT_WIDTH'(i)) matrix_out[i] <= bus.s_data;
            end
        end
    end

endmodule

// File: tb/tb_activation_stream_packer.sv
// Directed bench for activation_stream_packer with a per-cycle behavioural model.
module tb_activation_stream_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned MS = 196;

    logic clk;
    logic rst;
    logic signed [DW-1:0] matrix_out [MS];
    logic [31:0] matrix_size_out;
    logic [1:0]  func_sel_out;
    logic        valid_out;
    logic        busy;
    logic        err_len;
    logic        err_cfg;

    int checks   = 0;
    int failures = 0;
    int issues   = 0;
    int s_hs_cnt = 0;

    activation_stream_packer_if #(.DATA_WIDTH(DW)) bus ();

    activation_stream_packer #(
        .DATA_WIDTH  (DW),
        .MATRIX_SIZE (MS),
        .CNT_WIDTH   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .matrix_out      (matrix_out),
        .matrix_size_out (matrix_size_out),
        .func_sel_out    (func_sel_out),
        .valid_out       (valid_out),
        .busy            (busy),
        .err_len         (err_len),
        .err_cfg         (err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: phase, buffer contents and flags from the handshake rules
    typedef enum int {M_IDLE, M_FILL, M_ISSUE} mphase_t;
    mphase_t             m_phase;
    int                  m_count;
    logic [31:0]         m_size;
    logic [1:0]          m_func;
    logic                m_err_len;
    logic                m_err_cfg;
    logic signed [DW-1:0] m_mat [MS];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= M_IDLE;
            m_count   <= 0;
            m_size    <= '0;
            m_func    <= '0;
            m_err_len <= 1'b0;
            m_err_cfg <= 1'b0;
            for (int i = 0; i < int'(MS); i++) m_mat[i] <= '0;
        end else begin
            case (m_phase)
                M_IDLE: if (bus.cfg_valid) begin
                    if (bus.cfg_size >= 32'd1 && bus.cfg_size <= 32'd196) begin
                        m_size  <= bus.cfg_size;
                        m_func  <= bus.cfg_func;
                        m_count <= 0;
                        m_phase <= M_FILL;
                        for (int i = 0; i < int'(MS); i++) m_mat[i] <= '0;
                    end else begin
                        m_err_cfg <= 1'b1;
                    end
                end
                M_FILL: if (bus.s_valid) begin
                    m_mat[m_count] <= bus.s_data;
                    m_count <= m_count + 1;
                    if (bus.s_last != (32'(m_count + 1) == m_size)) m_err_len <= 1'b1;
                    if (bus.s_last || (32'(m_count + 1) == m_size)) m_phase <= M_ISSUE;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int bad;
        check("cfg_ready", bus.cfg_ready, (m_phase == M_IDLE) && !rst);
        check("s_ready", bus.s_ready, (m_phase == M_FILL) && !rst);
        check("valid_out", valid_out, m_phase == M_ISSUE);
        check("busy", busy, m_phase != M_IDLE);
        check("err_len", err_len, m_err_len);
        check("err_cfg", err_cfg, m_err_cfg);
        check("matrix_size_out", matrix_size_out, m_size);
        check("func_sel_out", func_sel_out, m_func);
        bad = -1;
        for (int i = 0; i < int'(MS); i++)
            if (bad < 0 && matrix_out[i] !== m_mat[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL matrix_out[%0d]: got %0d expected %0d", bad, matrix_out[bad], m_mat[bad]);
        end
        if (valid_out === 1'b1) issues++;
        if (bus.s_valid && bus.s_ready) s_hs_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int size, input int func);
        bit ok = 0;
        bit hs;
        bus.cfg_valid = 1'b1;
        bus.cfg_size  = 32'(size);
        bus.cfg_func  = 2'(func);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            hs = bus.cfg_ready;
            step();
            if (hs) begin ok = 1; break; end
        end
        bus.cfg_valid = 1'b0;
        check("cfg_handshake_timeout", ok, 1);
    endtask

    task automatic send_elem(input int d, input bit last, input int gap);
        bit ok = 0;
        bit hs;
        repeat (gap) step();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'(d);
        bus.s_last  = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            hs = bus.s_ready;
            step();
            if (hs) begin ok = 1; break; end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("elem_handshake_timeout", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_issues;
        int base_hs;
        int vals [4];
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_size  = '0;
        bus.cfg_func  = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        repeat (2) step();
        check("reset_valid_out", valid_out, 0);
        check("reset_cfg_ready", bus.cfg_ready, 0);
        check("reset_matrix0", matrix_out[0], 0);
        rst = 1'b0;
        step();

        // Size 4, ReLU, exact-length stream
        vals = '{-5, 3, 127, -128};
        send_cfg(4, 0);
        for (int i = 0; i < 4; i++) send_elem(vals[i], i == 3, 0);
        @(negedge clk);
        check("t1_valid_latency", valid_out, 1);
        check("t1_slot0", matrix_out[0], -5);
        check("t1_slot1", matrix_out[1], 3);
        check("t1_slot2", matrix_out[2], 127);
        check("t1_slot3", matrix_out[3], -128);
        check("t1_slot4", matrix_out[4], 0);
        check("t1_slot195", matrix_out[195], 0);
        check("t1_size", matrix_size_out, 4);
        check("t1_func", func_sel_out, 0);
        check("t1_err_len", err_len, 0);
        step();

        // Full 196-element matrix, Softmax, random stalls
        base_issues = issues;
        base_hs = s_hs_cnt;
        send_cfg(196, 3);
        for (int i = 0; i < 196; i++) send_elem(i % 128, i == 195, int'($urandom_range(0, 2)));
        @(negedge clk);
        check("t2_valid", valid_out, 1);
        check("t2_s_ready_issue", bus.s_ready, 0);
        check("t2_slot127", matrix_out[127], 127);
        check("t2_slot128", matrix_out[128], 0);
        check("t2_slot195", matrix_out[195], 67);
        check("t2_func", func_sel_out, 3);
        step();
        step();
        check("t2_handshakes", s_hs_cnt - base_hs, 196);
        check("t2_issue_pulses", issues - base_issues, 1);

        // Early s_last
        send_cfg(6, 2);
        for (int i = 0; i < 3; i++) send_elem(i + 1, i == 2, 0);
        @(negedge clk);
        check("t3_valid", valid_out, 1);
        check("t3_slot2", matrix_out[2], 3);
        check("t3_slot3", matrix_out[3], 0);
        check("t3_slot5", matrix_out[5], 0);
        check("t3_err_len", err_len, 1);
        step();

        // Bad configs are consumed and flagged
        base_issues = issues;
        send_cfg(0, 1);
        send_cfg(300, 1);
        repeat (2) step();
        check("t4_err_cfg", err_cfg, 1);
        check("t4_busy", busy, 0);
        check("t4_s_ready", bus.s_ready, 0);
        check("t4_no_issue", issues - base_issues, 0);

        // Reset mid-fill aborts
        send_cfg(5, 1);
        send_elem(11, 0, 0);
        send_elem(22, 0, 0);
        base_issues = issues;
        rst = 1'b1;
        #1;
        check("t5_slot0_after_rst", matrix_out[0], 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_err_len_after_rst", err_len, 0);
        check("t5_s_ready_after_rst", bus.s_ready, 0);
        step();
        rst = 1'b0;
        step();
        check("t5_no_issue", issues - base_issues, 0);
        send_cfg(2, 0);
        send_elem(7, 0, 0);
        send_elem(-7, 1, 0);
        @(negedge clk);
        check("t5_valid", valid_out, 1);
        check("t5_slot1", matrix_out[1], -7);
        check("t5_err_len", err_len, 0);
        check("t5_err_cfg", err_cfg, 0);
        step();

        // Back-to-back: config offered during ISSUE
        send_cfg(2, 1);
        send_elem(10, 0, 0);
        send_elem(-10, 1, 0);
        bus.cfg_valid = 1'b1;
        bus.cfg_size  = 32'd3;
        bus.cfg_func  = 2'd2;
        @(negedge clk);
        check("t6_valid", valid_out, 1);
        check("t6_cfg_ready_issue", bus.cfg_ready, 0);
        step();
        @(negedge clk);
        check("t6_cfg_ready_idle", bus.cfg_ready, 1);
        check("t6_hold_slot0", matrix_out[0], 10);
        check("t6_hold_size", matrix_size_out, 2);
        step();
        bus.cfg_valid = 1'b0;
        check("t6_cleared_slot0", matrix_out[0], 0);
        check("t6_new_size", matrix_size_out, 3);
        check("t6_busy", busy, 1);
        for (int i = 0; i < 3; i++) send_elem(i - 1, i == 2, 0);
        @(negedge clk);
        check("t6_second_valid", valid_out, 1);
        check("t6_second_slot0", matrix_out[0], -1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
